// File: rtl/dimm_bank_tracker.sv
// DDR4-style command bus monitor: decodes per-rank commands, tracks each
// bank's ACT/PRE life cycle and the rank refresh window, and reports every
// accepted command or rejected (illegal) command one registered cycle later.
//
// Bank state encoding on dbg_bank_state_o (2 bits per bank, index rank*NB+bank):
//   0 IDLE, 1 ACTIVATING, 2 ACTIVE, 3 PRECHARGING.
//
// Outputs are registered pulses with no back-pressure: cmd_valid means
// "the command sampled at the previous edge was legal and applied",
// violation means "it was rejected"; the two are never high together.
module dimm_bank_tracker #(
  parameter int ADDRWIDTH     = 17,
  parameter int RANKS         = 2,
  parameter int BANKGROUPS    = 4,
  parameter int BANKSPERGROUP = 4,
  parameter int tRCD          = 4,
  parameter int tRP           = 4,
  parameter int tRAS          = 10,
  parameter int tRFC          = 20,
  localparam int NB  = BANKGROUPS * BANKSPERGROUP,
  localparam int TB  = RANKS * NB,
  localparam int RW  = (RANKS > 1) ? $clog2(RANKS) : 1,
  localparam int BGW = (BANKGROUPS > 1) ? $clog2(BANKGROUPS) : 1,
  localparam int BAW = (BANKSPERGROUP > 1) ? $clog2(BANKSPERGROUP) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cke,
  input  logic [RANKS-1:0]          cs_n,
  input  logic                      act_n,
  input  logic [ADDRWIDTH-1:0]      A,
  input  logic [BGW-1:0]            bg,
  input  logic [BAW-1:0]            ba,
  output logic                      cmd_valid,
  output logic [3:0]                cmd_code,
  output logic [RW-1:0]             cmd_rank,
  output logic [TB-1:0]             bank_open,
  output logic [TB*ADDRWIDTH-1:0]   open_row,
  output logic                      violation,
  output logic [2:0]                viol_code,
  output logic [TB*2-1:0]           dbg_bank_state_o
);

  localparam int BKW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int CMAX = (tRAS > tRCD) ? ((tRAS > tRP) ? tRAS : tRP)
                                      : ((tRCD > tRP) ? tRCD : tRP);
  localparam int CW   = $clog2(CMAX + 1);
  localparam int RFW  = $clog2(tRFC + 1);

  localparam logic [CW-1:0]  TRCD_C = CW'(tRCD);
  localparam logic [CW-1:0]  TRP_C  = CW'(tRP);
  localparam logic [CW-1:0]  TRAS_C = CW'(tRAS);
  localparam logic [CW-1:0]  CMAX_C = CW'(CMAX);
  localparam logic [RFW-1:0] TRFC_C = RFW'(tRFC);

  localparam logic [3:0] C_NOP  = 4'd0;
  localparam logic [3:0] C_ACT  = 4'd1;
  localparam logic [3:0] C_RD   = 4'd2;
  localparam logic [3:0] C_WR   = 4'd3;
  localparam logic [3:0] C_PRE  = 4'd4;
  localparam logic [3:0] C_PREA = 4'd5;
  localparam logic [3:0] C_REF  = 4'd6;
  localparam logic [3:0] C_RDA  = 4'd7;
  localparam logic [3:0] C_WRA  = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_ACTIVATING  = 2'd1,
    S_ACTIVE      = 2'd2,
    S_PRECHARGING = 2'd3
  } bank_state_e;

  // Per-bank state. cnt_q counts edges since the last ACT or precharge start,
  // so one saturating counter serves tRCD/tRAS and tRP.
  bank_state_e          state_q [TB];
  bank_state_e          state_d [TB];
  bank_state_e          eff     [TB];
  logic [CW-1:0]        cnt_q   [TB];
  logic [CW-1:0]        cnt_d   [TB];
  logic                 ap_q    [TB];
  logic                 ap_d    [TB];
  logic [ADDRWIDTH-1:0] row_q   [TB];
  logic [ADDRWIDTH-1:0] row_d   [TB];

  // Per-rank refresh window.
  logic                 ref_q   [RANKS];
  logic                 ref_d   [RANKS];
  logic [RFW-1:0]       rcnt_q  [RANKS];
  logic [RFW-1:0]       rcnt_d  [RANKS];
  logic                 refr_eff   [RANKS];
  logic                 tras_block [RANKS];
  logic                 rank_busy  [RANKS];

  // Decode and target lookup.
  logic [3:0]     cmd;
  int             n_low;
  logic [RW-1:0]  rank_sel;
  logic [BKW-1:0] bank_sel;
  bank_state_e    tgt_eff;
  logic           tgt_ap;
  logic           tgt_tras_unmet;
  logic           tgt_ref;
  logic           tgt_rank_tras;
  logic           tgt_busy;
  logic           acc;
  logic           vio;
  logic [2:0]     vcode;

  // Output registers.
  logic           cmd_valid_q;
  logic [3:0]     cmd_code_q;
  logic [RW-1:0]  cmd_rank_q;
  logic           violation_q;
  logic [2:0]     viol_code_q;

  // Command decode and chip-select analysis.
  always_comb begin
    cmd = C_NOP;
    if (!act_n) begin
      cmd = C_ACT;
    end else begin
      case (A[16:14])
        3'b010:  cmd = A[10] ? C_PREA : C_PRE;
        3'b101:  cmd = A[10] ? C_RDA  : C_RD;
        3'b100:  cmd = A[10] ? C_WRA  : C_WR;
        3'b001:  cmd = C_REF;
        default: cmd = C_NOP;
      endcase
    end
    n_low    = 0;
    rank_sel = '0;
    for (int r = 0; r < RANKS; r++) begin
      if (!cs_n[r]) begin
        n_low    = n_low + 1;
        rank_sel = RW'(r);
      end
    end
    bank_sel = BKW'(bg) * BKW'(BANKSPERGROUP) + BKW'(ba);
  end

  // Effective state at this edge: timers that have expired complete their
  // transition now, so a RD exactly at ACT+tRCD or an ACT exactly at PRE+tRP
  // is judged against the finished state.
  always_comb begin
    for (int i = 0; i < TB; i++) begin
      eff[i] = state_q[i];
      if (state_q[i] == S_ACTIVATING && cnt_q[i] >= TRCD_C) eff[i] = S_ACTIVE;
      if (state_q[i] == S_PRECHARGING && cnt_q[i] >= TRP_C) eff[i] = S_IDLE;
    end
  end

  // Per-rank summaries and the properties of the addressed bank.
  always_comb begin
    tgt_eff        = S_IDLE;
    tgt_ap         = 1'b0;
    tgt_tras_unmet = 1'b0;
    tgt_ref        = 1'b0;
    tgt_rank_tras  = 1'b0;
    tgt_busy       = 1'b0;
    for (int r = 0; r < RANKS; r++) begin
      refr_eff[r]   = ref_q[r] && (rcnt_q[r] < TRFC_C);
      tras_block[r] = 1'b0;
      rank_busy[r]  = 1'b0;
      for (int b = 0; b < NB; b++) begin
        if ((eff[r*NB+b] == S_ACTIVE || eff[r*NB+b] == S_ACTIVATING) &&
            cnt_q[r*NB+b] < TRAS_C)
          tras_block[r] = 1'b1;
        if (eff[r*NB+b] != S_IDLE) rank_busy[r] = 1'b1;
      end
      if (RW'(r) == rank_sel) begin
        tgt_ref       = refr_eff[r];
        tgt_rank_tras = tras_block[r];
        tgt_busy      = rank_busy[r];
        for (int b = 0; b < NB; b++) begin
          if (BKW'(b) == bank_sel) begin
            tgt_eff        = eff[r*NB+b];
            tgt_ap         = ap_q[r*NB+b];
            tgt_tras_unmet = cnt_q[r*NB+b] < TRAS_C;
          end
        end
      end
    end
  end

  // Legality check; the if/else order is the violation priority.
  always_comb begin
    acc   = 1'b0;
    vio   = 1'b0;
    vcode = 3'd0;
    if (cke && n_low > 1) begin
      vio   = 1'b1;
      vcode = 3'd7;
    end else if (cke && n_low == 1 && cmd != C_NOP) begin
      if (tgt_ref) begin
        vio = 1'b1; vcode = 3'd6;
      end else begin
        case (cmd)
          C_ACT: begin
            if (tgt_eff != S_IDLE) begin vio = 1'b1; vcode = 3'd1; end
          end
          C_RD, C_WR, C_RDA, C_WRA: begin
            if (tgt_eff == S_ACTIVATING) begin
              vio = 1'b1; vcode = 3'd3;
            end else if (tgt_eff != S_ACTIVE || tgt_ap) begin
              vio = 1'b1; vcode = 3'd2;
            end
          end
          C_PRE: begin
            if (tgt_ap) begin
              vio = 1'b1; vcode = 3'd2;
            end else if ((tgt_eff == S_ACTIVE || tgt_eff == S_ACTIVATING) &&
                         tgt_tras_unmet) begin
              vio = 1'b1; vcode = 3'd4;
            end
          end
          C_PREA: begin
            if (tgt_rank_tras) begin vio = 1'b1; vcode = 3'd4; end
          end
          C_REF: begin
            if (tgt_busy) begin vio = 1'b1; vcode = 3'd5; end
          end
          default: ;
        endcase
      end
      acc = !vio;
    end
  end

  // Next-state: timer progression and auto-precharge every edge, plus the
  // effect of an accepted command. Rejected commands change nothing.
  always_comb begin
    for (int r = 0; r < RANKS; r++) begin
      for (int b = 0; b < NB; b++) begin
        state_d[r*NB+b] = eff[r*NB+b];
        cnt_d[r*NB+b]   = (cnt_q[r*NB+b] == CMAX_C) ? cnt_q[r*NB+b]
                                                    : cnt_q[r*NB+b] + 1'b1;
        ap_d[r*NB+b]    = ap_q[r*NB+b];
        row_d[r*NB+b]   = row_q[r*NB+b];
        if (eff[r*NB+b] == S_IDLE) ap_d[r*NB+b] = 1'b0;
        // Pending auto-precharge fires once tRAS is met (never on the RDA/WRA edge itself).
        if (ap_q[r*NB+b] && eff[r*NB+b] == S_ACTIVE && cnt_q[r*NB+b] >= TRAS_C) begin
          state_d[r*NB+b] = S_PRECHARGING;
          cnt_d[r*NB+b]   = CW'(1);
        end
        if (acc && RW'(r) == rank_sel) begin
          if ((cmd == C_PREA || (cmd == C_PRE && BKW'(b) == bank_sel)) &&
              (eff[r*NB+b] == S_ACTIVE || eff[r*NB+b] == S_ACTIVATING)) begin
            state_d[r*NB+b] = S_PRECHARGING;
            cnt_d[r*NB+b]   = CW'(1);
          end
          if (BKW'(b) == bank_sel) begin
            if (cmd == C_ACT) begin
              state_d[r*NB+b] = S_ACTIVATING;
              cnt_d[r*NB+b]   = CW'(1);
              row_d[r*NB+b]   = A;
              ap_d[r*NB+b]    = 1'b0;
            end
            if (cmd == C_RDA || cmd == C_WRA) ap_d[r*NB+b] = 1'b1;
          end
        end
      end
      ref_d[r]  = refr_eff[r];
      rcnt_d[r] = (rcnt_q[r] == TRFC_C) ? rcnt_q[r] : rcnt_q[r] + 1'b1;
      if (acc && cmd == C_REF && RW'(r) == rank_sel) begin
        ref_d[r]  = 1'b1;
        rcnt_d[r] = RFW'(1);
      end
    end
  end

  // State register: banks, timers, latched rows and refresh windows.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TB; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
        ap_q[i]    <= 1'b0;
        row_q[i]   <= '0;
      end
      for (int r = 0; r < RANKS; r++) begin
        ref_q[r]  <= 1'b0;
        rcnt_q[r] <= '0;
      end
    end else begin
      for (int i = 0; i < TB; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        ap_q[i]    <= ap_d[i];
        row_q[i]   <= row_d[i];
      end
      for (int r = 0; r < RANKS; r++) begin
        ref_q[r]  <= ref_d[r];
        rcnt_q[r] <= rcnt_d[r];
      end
    end
  end

  // Registered command/violation report for the command sampled this edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= C_NOP;
      cmd_rank_q  <= '0;
      violation_q <= 1'b0;
      viol_code_q <= 3'd0;
    end else begin
      cmd_valid_q <= acc;
      cmd_code_q  <= acc ? cmd : C_NOP;
      cmd_rank_q  <= (acc || (vio && vcode != 3'd7)) ? rank_sel : '0;
      violation_q <= vio;
      viol_code_q <= vio ? vcode : 3'd0;
    end
  end

  // Output decode: open-bank map, latched rows and state debug view.
  always_comb begin
    for (int i = 0; i < TB; i++) begin
      bank_open[i]                          = (state_q[i] == S_ACTIVE);
      open_row[i*ADDRWIDTH +: ADDRWIDTH]    = row_q[i];
      dbg_bank_state_o[i*2 +: 2]            = state_q[i];
    end
    cmd_valid = cmd_valid_q;
    cmd_code  = cmd_code_q;
    cmd_rank  = cmd_rank_q;
    violation = violation_q;
    viol_code = viol_code_q;
  end

endmodule

// File: tb/tb_dimm_bank_tracker.sv
// Directed bench for dimm_bank_tracker at default timing (tRCD=4, tRP=4,
// tRAS=10, tRFC=20). Edge numbers in comments are relative to each scenario.
module tb_dimm_bank_tracker;

  localparam int AW = 17;
  localparam int NB = 16;

  localparam int C_ACT  = 1;
  localparam int C_RD   = 2;
  localparam int C_WR   = 3;
  localparam int C_PRE  = 4;
  localparam int C_PREA = 5;
  localparam int C_REF  = 6;
  localparam int C_RDA  = 7;
  localparam int C_WRA  = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              cke;
  logic [1:0]        cs_n;
  logic              act_n;
  logic [AW-1:0]     A;
  logic [1:0]        bg;
  logic [1:0]        ba;
  logic              cmd_valid;
  logic [3:0]        cmd_code;
  logic [0:0]        cmd_rank;
  logic [2*NB-1:0]   bank_open;
  logic [2*NB*AW-1:0] open_row;
  logic              violation;
  logic [2:0]        viol_code;
  logic [2*NB*2-1:0] dbg_bank_state_o;

  int n_cmp = 0;
  int n_bad = 0;
  // Expected report: {violation, code (cmd_code or viol_code), rank}
  logic [5:0] exp_q[$];

  dimm_bank_tracker dut (
    .clk(clk), .reset_n(reset_n), .cke(cke), .cs_n(cs_n), .act_n(act_n),
    .A(A), .bg(bg), .ba(ba), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_rank(cmd_rank), .bank_open(bank_open), .open_row(open_row),
    .violation(violation), .viol_code(viol_code),
    .dbg_bank_state_o(dbg_bank_state_o)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  function automatic logic [AW-1:0] enc(input int code, input logic [AW-1:0] row);
    logic [AW-1:0] a;
    a = '0;
    case (code)
      C_ACT:  a = row;
      C_PRE:  begin a[16:14] = 3'b010; a[10] = 1'b0; end
      C_PREA: begin a[16:14] = 3'b010; a[10] = 1'b1; end
      C_RD:   begin a[16:14] = 3'b101; a[10] = 1'b0; end
      C_RDA:  begin a[16:14] = 3'b101; a[10] = 1'b1; end
      C_WR:   begin a[16:14] = 3'b100; a[10] = 1'b0; end
      C_WRA:  begin a[16:14] = 3'b100; a[10] = 1'b1; end
      C_REF:  a[16:14] = 3'b001;
      default: a = '0;
    endcase
    return a;
  endfunction

  // Drive one cycle of bus values; returns at the next falling edge.
  task automatic drive(input logic k, input logic [1:0] cs, input logic an,
                       input logic [AW-1:0] a, input logic [3:0] bank);
    cke = k; cs_n = cs; act_n = an; A = a; bg = bank[3:2]; ba = bank[1:0];
    @(negedge clk);
  endtask

  task automatic nop(input int n);
    repeat (n) drive(1'b1, 2'b11, 1'b1, '0, 4'd0);
  endtask

  // Issue a single-rank command and post the expected report.
  task automatic issue(input int rank, input int code, input int bank,
                       input logic [AW-1:0] row, input logic ev, input int ecode);
    logic [1:0] cs;
    cs = 2'b11;
    cs[rank] = 1'b0;
    exp_q.push_back({ev, 4'(ecode), 1'(rank)});
    drive(1'b1, cs, (code == C_ACT) ? 1'b0 : 1'b1, enc(code, row), 4'(bank));
  endtask

  function automatic logic [AW-1:0] row_of(input int idx);
    return open_row[idx*AW +: AW];
  endfunction

  // Scoreboard monitor: pops an expectation whenever the DUT reports.
  initial begin
    logic [5:0] e;
    logic [5:0] got;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && (cmd_valid || violation)) begin
        if (cmd_valid && violation) chk("valid_and_violation", 64'(1), 64'(0));
        got = {violation, violation ? {1'b0, viol_code} : cmd_code, cmd_rank};
        if (exp_q.size() == 0) begin
          chk("unexpected_report", 64'(got), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("report", 64'(got), 64'(e));
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0; cke = 1'b0; cs_n = 2'b11; act_n = 1'b1; A = '0; bg = '0; ba = '0;
    repeat (2) @(negedge clk);
    chk("rst_bank_open", 64'(bank_open), 64'(0));
    chk("rst_open_row_or", 64'(|open_row), 64'(0));
    chk("rst_cmd_valid", 64'(cmd_valid), 64'(0));
    chk("rst_cmd_code", 64'(cmd_code), 64'(0));
    chk("rst_cmd_rank", 64'(cmd_rank), 64'(0));
    chk("rst_violation", 64'(violation), 64'(0));
    chk("rst_viol_code", 64'(viol_code), 64'(0));
    reset_n = 1'b1;

    // A: ACT r0 b5 row 1ABC @0, RD @4, WR @5, PRE @10
    issue(0, C_ACT, 5, 17'h1ABC, 1'b0, C_ACT);
    chk("a_open_after_act", 64'(bank_open[5]), 64'(0));
    chk("a_dbg_activating", 64'(dbg_bank_state_o[5*2 +: 2]), 64'(1));
    nop(3);
    chk("a_open_edge3", 64'(bank_open[5]), 64'(0));
    issue(0, C_RD, 5, '0, 1'b0, C_RD);
    chk("a_open_edge4", 64'(bank_open[5]), 64'(1));
    chk("a_row", 64'(row_of(5)), 64'(17'h1ABC));
    issue(0, C_WR, 5, '0, 1'b0, C_WR);
    nop(4);
    issue(0, C_PRE, 5, '0, 1'b0, C_PRE);
    chk("a_open_after_pre", 64'(bank_open[5]), 64'(0));
    nop(3);

    // B: ACT r0 b2 @0, RD @2 (3), PRE @5 (4), PRE @10 ok, ACT @13 (1), ACT @14 ok
    issue(0, C_ACT, 2, 17'h00123, 1'b0, C_ACT);
    nop(1);
    issue(0, C_RD, 2, '0, 1'b1, 3);
    nop(2);
    issue(0, C_PRE, 2, '0, 1'b1, 4);
    chk("b_open_kept", 64'(bank_open[2]), 64'(1));
    nop(4);
    issue(0, C_PRE, 2, '0, 1'b0, C_PRE);
    nop(2);
    issue(0, C_ACT, 2, 17'h0BEEF, 1'b1, 1);
    chk("b_row_unchanged", 64'(row_of(2)), 64'(17'h00123));
    issue(0, C_ACT, 2, 17'h04567, 1'b0, C_ACT);
    chk("b_row_new", 64'(row_of(2)), 64'(17'h04567));
    issue(0, C_PRE, 7, '0, 1'b0, C_PRE);  // PRE to idle bank is a no-op

    // C: ACT r1 b0 @0, RDA @4, RD @6 (2), PRECHARGING @10, ACT @12 (1), ACT @14 ok
    issue(1, C_ACT, 0, 17'h1F00F, 1'b0, C_ACT);
    nop(3);
    issue(1, C_RDA, 0, '0, 1'b0, C_RDA);
    nop(1);
    issue(1, C_RD, 0, '0, 1'b1, 2);
    nop(3);
    chk("c_open_edge9", 64'(bank_open[NB+0]), 64'(1));
    nop(1);
    chk("c_open_edge10", 64'(bank_open[NB+0]), 64'(0));
    chk("c_dbg_precharging", 64'(dbg_bank_state_o[NB*2 +: 2]), 64'(3));
    nop(1);
    issue(1, C_ACT, 0, 17'h00001, 1'b1, 1);
    nop(1);
    issue(1, C_ACT, 0, 17'h00002, 1'b0, C_ACT);
    chk("c_row", 64'(row_of(NB+0)), 64'(17'h00002));

    // D: ACT r0 b3 @0, REF @4 (5), PREA @5 (4), PREA @10 ok, REF @14 ok,
    //    ACT r0 @15 (6), ACT r1 b1 @16 ok, PRE r0 @33 (6), ACT r0 @34 ok
    issue(0, C_ACT, 3, 17'h00333, 1'b0, C_ACT);
    nop(3);
    issue(0, C_REF, 0, '0, 1'b1, 5);
    issue(0, C_PREA, 0, '0, 1'b1, 4);
    nop(4);
    issue(0, C_PREA, 0, '0, 1'b0, C_PREA);
    chk("d_rank0_closed", 64'(bank_open[NB-1:0]), 64'(0));
    nop(3);
    issue(0, C_REF, 0, '0, 1'b0, C_REF);
    issue(0, C_ACT, 4, 17'h00444, 1'b1, 6);
    issue(1, C_ACT, 1, 17'h00555, 1'b0, C_ACT);
    nop(16);
    issue(0, C_PRE, 0, '0, 1'b1, 6);
    issue(0, C_ACT, 0, 17'h00666, 1'b0, C_ACT);

    // E: two chip selects low, then cke low
    exp_q.push_back({1'b1, 4'd7, 1'b0});
    drive(1'b1, 2'b00, 1'b0, 17'h00999, 4'd9);
    chk("e_multi_no_open", 64'(dbg_bank_state_o[9*2 +: 2]), 64'(0));
    chk("e_multi_no_row", 64'(row_of(9)), 64'(0));
    drive(1'b0, 2'b10, 1'b0, 17'h00999, 4'd9);
    chk("e_cke_low_no_state", 64'(dbg_bank_state_o[9*2 +: 2]), 64'(0));
    nop(1);

    // F: reset pulse while a bank is activating
    issue(0, C_ACT, 9, 17'h00ABC, 1'b0, C_ACT);
    #2;
    reset_n = 1'b0;
    #1;
    chk("f_rst_bank_open", 64'(bank_open), 64'(0));
    chk("f_rst_dbg", 64'(dbg_bank_state_o), 64'(0));
    chk("f_rst_cmd_valid", 64'(cmd_valid), 64'(0));
    chk("f_rst_row", 64'(|open_row), 64'(0));
    cke = 1'b1; cs_n = 2'b11; act_n = 1'b1; A = '0;
    @(negedge clk);
    reset_n = 1'b1;
    issue(0, C_RD, 9, '0, 1'b1, 2);
    issue(0, C_WRA, 9, '0, 1'b1, 2);

    nop(3);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
